seq_scan_ctrl: RTL and testbench

Controller that sequences the serial "100" sequence analyzer across a parallel data word. It accepts a WIDTH-bit word over a valid/ready handshake and clears the analyzer. It then streams the word into the analyzer's serial input one bit per cycle and counts the analyzer's match pulses. The count is returned over a second valid/ready handshake. It sits between a word-oriented producer and the analyzer instance, which it owns exclusively.

---
 rtl/seq_scan_pkg.sv | 32 +++
 rtl/seq_scan_shifter.sv | 66 ++++++
 rtl/seq_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_seq_scan_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// ============================================================================
// Module      : seq_scan_pkg
// Description : Shared types and helpers for the "100" sequence-scan
//               controller. Holds the FSM state enum, the default
//               word/counter widths and the saturating-increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_scan_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CNT_W = 5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_REPORT = 3'd4
   } state_t;

   // Increment value by one, sticking at the all-ones value of a width-bit field.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
      logic [31:0] max_v;
      max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value >= max_v) ? max_v : (value + 32'd1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_scan_shifter.sv
// ============================================================================
// Module      : seq_scan_shifter
// Description : Parallel-in / serial-out shift register with a down-counting
//               bit counter. Flags the cycle in which the final bit of the
//               word is presented. Build option SEQ_SCAN_LSB_FIRST_EN selects
//               LSB-first (shift right) instead of the default MSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_scan_shifter
   import seq_scan_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             start,
   input  logic             shift_en,
   output logic             serial_bit,
   output logic             last
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] r_shreg;
   logic [BW-1:0]    r_bitcnt;
   logic [WIDTH-1:0] w_shifted;

`ifdef SEQ_SCAN_LSB_FIRST_EN
   assign serial_bit = r_shreg[0];
   assign w_shifted  = {1'b0, r_shreg[WIDTH-1:1]};
`else
   assign serial_bit = r_shreg[WIDTH-1];
   assign w_shifted  = {r_shreg[WIDTH-2:0], 1'b0};
`endif

   // Capture a new word or advance it by one bit position.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shreg <= '0;
      end else if (load) begin
         r_shreg <= data;
      end else if (shift_en) begin
         r_shreg <= w_shifted;
      end
   end

   // Count remaining bits; reaching zero marks the final bit on the line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bitcnt <= '0;
      end else if (start) begin
         r_bitcnt <= BW'(WIDTH - 1);
      end else if (shift_en && (r_bitcnt != '0)) begin
         r_bitcnt <= r_bitcnt - BW'(1);
      end
   end

   assign last = (r_bitcnt == '0);

endmodule

`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
// ============================================================================
// Module      : seq_scan_ctrl
// Description : Accepts a word over valid/ready, clears the external "100"
//               analyzer, streams the word into it one bit per cycle, counts
//               the analyzer's match pulses (saturating) and returns the count
//               over a result valid/ready handshake. Latency WIDTH+2 cycles.
//               Build option SEQ_SCAN_LSB_FIRST_EN sends the word LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_scan_ctrl
   import seq_scan_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] res_count,
   output logic             sd_clear,
   output logic             sd_serial,
   input  logic             sd_hit
);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_count;

   logic w_load;
   logic w_start;
   logic w_shift_en;
   logic w_cnt_clr;
   logic w_cnt_en;
   logic w_serial_bit;
   logic w_last;

   seq_scan_shifter #(
      .WIDTH (WIDTH)
   ) u_shifter (
      .clk        (clk),
      .reset      (reset),
      .load       (w_load),
      .data       (in_data),
      .start      (w_start),
      .shift_en   (w_shift_en),
      .serial_bit (w_serial_bit),
      .last       (w_last)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and Moore outputs; the analyzer stays parked while idle.
   always_comb begin
      w_next     = r_state;
      in_ready   = 1'b0;
      res_valid  = 1'b0;
      sd_clear   = 1'b0;
      w_load     = 1'b0;
      w_start    = 1'b0;
      w_shift_en = 1'b0;
      w_cnt_clr  = 1'b0;
      w_cnt_en   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            sd_clear = 1'b1;
            if (in_valid) begin
               w_load    = 1'b1;
               w_cnt_clr = 1'b1;
               w_next    = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            sd_clear = 1'b1;
            w_start  = 1'b1;
            w_next   = ST_SHIFT;
         end
         ST_SHIFT: begin
            w_shift_en = 1'b1;
            w_cnt_en   = 1'b1;
            if (w_last) begin
               w_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            w_cnt_en = 1'b1;
            w_next   = ST_REPORT;
         end
         ST_REPORT: begin
            res_valid = 1'b1;
            if (res_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   assign sd_serial = (r_state == ST_SHIFT) && w_serial_bit;

   // Match counter; hits are one cycle late, so DRAIN picks up the last bit's hit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (w_cnt_clr) begin
         r_count <= '0;
      end else if (w_cnt_en && sd_hit) begin
         r_count <= CNT_W'(sat_inc(32'(r_count), CNT_W));
      end
   end

   assign res_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
// ============================================================================
// Module      : tb_seq_scan_ctrl
// Description : Self-checking bench for seq_scan_ctrl with a behavioural
//               "100" analyzer attached. Honours SEQ_SCAN_LSB_FIRST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_scan_ctrl;

   localparam int WIDTH   = 16;
   localparam int CNT_W   = 5;
   localparam int LATENCY = WIDTH + 2;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [CNT_W-1:0] res_count;
   logic             sd_clear;
   logic             sd_serial;
   logic             sd_hit;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   seq_scan_ctrl #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_count (res_count),
      .sd_clear  (sd_clear),
      .sd_serial (sd_serial),
      .sd_hit    (sd_hit)
   );

   // Serial "100" analyzer (Moore): progress 0 none, 1 "1", 2 "10", 3 "100".
   logic [1:0] an_st = 2'd0;
   always @(posedge clk) begin
      if (sd_clear)       an_st <= 2'd0;
      else if (sd_serial) an_st <= 2'd1;
      else if (an_st == 2'd1) an_st <= 2'd2;
      else if (an_st == 2'd2) an_st <= 2'd3;
      else                an_st <= 2'd0;
   end
   assign sd_hit = (an_st == 2'd3);

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Word in the order its bits go onto the serial line (first bit in MSB).
   function automatic logic [WIDTH-1:0] send_order(input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
`ifdef SEQ_SCAN_LSB_FIRST_EN
      for (int i = 0; i < WIDTH; i++) r[WIDTH-1-i] = d[i];
`else
      r = d;
`endif
      return r;
   endfunction

   // Reference: number of "1,0,0" windows in the serial stream, saturated.
   function automatic int ref_count(input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] s;
      int cnt;
      s   = send_order(d);
      cnt = 0;
      for (int i = WIDTH - 1; i >= 2; i--)
         if (s[i] && !s[i-1] && !s[i-2]) cnt++;
      return (cnt > (2**CNT_W - 1)) ? (2**CNT_W - 1) : cnt;
   endfunction

   // One full transaction starting in IDLE, a little after a rising edge.
   task automatic run_word(input logic [WIDTH-1:0] d, input int exp, input int bp,
                           input string name);
      int               cyc;
      logic [WIDTH-1:0] ser;
      logic [WIDTH-1:0] exp_ser;
      logic             drain_hit;
      logic             stable_ok;
      exp_ser = send_order(d);
      chk({name, " in_ready idle"}, int'(in_ready), 1);
      in_data  = d;
      in_valid = 1'b1;
      res_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
      chk({name, " clear phase"}, int'({sd_clear, in_ready}), 2);
      cyc = 0;
      ser = '0;
      drain_hit = 1'b0;
      while (!res_valid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc >= 1 && cyc <= WIDTH) ser = {ser[WIDTH-2:0], sd_serial};
         if (cyc == WIDTH + 1) begin
            drain_hit = sd_hit;
            chk({name, " serial 0 in drain"}, int'(sd_serial), 0);
         end
      end
      chk({name, " latency"}, cyc, LATENCY);
      chk({name, " serial stream"}, int'(ser), int'(exp_ser));
      chk({name, " drain hit"}, int'(drain_hit), int'(exp_ser[2:0] == 3'b100));
      chk({name, " res_count"}, int'(res_count), exp);
      stable_ok = 1'b1;
      for (int i = 0; i < bp; i++) begin
         in_valid = ~in_valid;
         in_data  = WIDTH'($urandom);
         @(posedge clk); #1;
         if (!res_valid || res_count != CNT_W'(exp) || in_ready) stable_ok = 1'b0;
      end
      in_valid = 1'b0;
      if (bp > 0) chk({name, " backpressure hold"}, int'(stable_ok), 1);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk({name, " back to idle"}, int'({in_ready, res_valid}), 2);
   endtask

   typedef struct {
      logic [WIDTH-1:0] data;
      int               exp;
      int               bp;
   } vec_t;

   vec_t vecs[7];

   initial begin
`ifdef SEQ_SCAN_LSB_FIRST_EN
      vecs[0] = '{16'h9249, 5, 0};
      vecs[1] = '{16'h0000, 0, 0};
      vecs[2] = '{16'hFFFF, 0, 0};
      vecs[3] = '{16'h8000, 0, 0};
      vecs[4] = '{16'h0004, 1, 0};
      vecs[5] = '{16'h0001, 1, 0};
      vecs[6] = '{16'h9249, 5, 10};
`else
      vecs[0] = '{16'h9249, 5, 0};
      vecs[1] = '{16'h0000, 0, 0};
      vecs[2] = '{16'hFFFF, 0, 0};
      vecs[3] = '{16'h8000, 1, 0};
      vecs[4] = '{16'h0004, 1, 0};
      vecs[5] = '{16'h0001, 0, 0};
      vecs[6] = '{16'h9249, 5, 10};
`endif

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("reset in_ready", int'(in_ready), 1);
      chk("reset sd_clear", int'(sd_clear), 1);
      chk("reset outputs", int'({sd_serial, res_valid}), 0);
      chk("reset res_count", int'(res_count), 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Directed table.
      for (int i = 0; i < 7; i++)
         run_word(vecs[i].data, vecs[i].exp, vecs[i].bp, $sformatf("vec%0d", i));

      // Word offered while not idle is not consumed: previous hold already
      // toggled in_valid, so the next word must still scan normally.
      run_word(16'h0004, 1, 0, "after_bp");

      // Reset during SHIFT cycle 7.
      in_data  = 16'h9249;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("midreset in_ready/sd_clear", int'({in_ready, sd_clear}), 3);
      chk("midreset serial/valid", int'({sd_serial, res_valid}), 0);
      chk("midreset res_count", int'(res_count), 0);
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #1;
      run_word(16'h9249, 5, 0, "post_reset");

      // Randomized words against the reference model.
      for (int i = 0; i < 30; i++) begin
         logic [WIDTH-1:0] d;
         d = WIDTH'($urandom);
         run_word(d, ref_count(d), int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
